// File: rtl/frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_serializer
//  Description : Asynchronous-style serial line framer. Accepts a payload
//                word over a valid/ready handshake and shifts it out as
//                START(0), DATA bits, optional PARITY, STOP(1) bit(s), with
//                each line bit held for BIT_PERIOD clocks.
//
//  Parameters  : DATA_WIDTH  payload bits per frame (>= 1)
//                BIT_PERIOD  clocks per line bit (>= 1)
//                MSB_FIRST   0 = LSB first, 1 = MSB first
//                STOP_BITS   number of stop bits (1 or 2)
//
//  Ports       : clock      in   rising-edge clock
//                reset      in   asynchronous, active-high reset
//                data_in    in   payload word (DATA_WIDTH bits)
//                valid_in   in   data_in is valid
//                ready_out  out  block can accept a word (IDLE only)
//                data_out   out  serial line, idle high (registered)
//                busy       out  frame in progress (registered)
//                done       out  one-clock pulse on return to IDLE (registered)
//
//  Build option: FRAME_SERIALIZER_PARITY_EN -- when defined, an even-parity
//                bit (XOR of the captured word) follows the payload.
//
//  Revision    : 1.0  initial release
// ============================================================================
module frame_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_PERIOD = 1,
    parameter int MSB_FIRST  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  data_out,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The bit counter carries one spare bit so that DATA_WIDTH-1 is always
    // representable, including DATA_WIDTH = 1 where $clog2 returns 0.
    localparam int c_CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam int c_PER_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LAST_DATA = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_STOP = c_CNT_W'(STOP_BITS - 1);
    localparam logic [c_PER_W-1:0] c_PER_ONE   = c_PER_W'(1);
    localparam logic [c_PER_W-1:0] c_LAST_TICK = c_PER_W'(BIT_PERIOD - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef FRAME_SERIALIZER_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_word;     // captured payload, frozen for the frame
    logic [c_CNT_W-1:0]    r_bit_cnt;  // data-bit index in DATA, stop index in STOP
    logic [c_PER_W-1:0]    r_period;   // clocks elapsed within the current line bit

    // ------------------------------------------------------------------------
    // Payload bit selection
    // ------------------------------------------------------------------------
    // w_ordered puts the payload in transmission order so that index 0 is
    // always the first bit on the line regardless of MSB_FIRST.
    logic [DATA_WIDTH-1:0] w_ordered;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            always_comb begin
                w_ordered = '0;
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    w_ordered[i] = r_word[DATA_WIDTH-1-i];
                end
            end
        end else begin : g_lsb_first
            assign w_ordered = r_word;
        end
    endgenerate

    // Index of the payload bit that goes on the line at the next bit
    // boundary: bit 0 when leaving START, the following bit while in DATA.
    logic [c_CNT_W-1:0] w_next_idx;
    logic               w_next_bit;

    assign w_next_idx = (r_state == S_DATA) ? (r_bit_cnt + c_CNT_ONE) : '0;

    // Compare-based mux keeps the index width independent of the payload
    // width and never reads outside the word.
    always_comb begin
        w_next_bit = 1'b1;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (w_next_idx == c_CNT_W'(i)) begin
                w_next_bit = w_ordered[i];
            end
        end
    end

`ifdef FRAME_SERIALIZER_PARITY_EN
    logic w_parity;
    assign w_parity = ^r_word;
`endif

    // Acceptance is possible only in IDLE; ready is a pure state decode.
    assign ready_out = (r_state == S_IDLE);

    // ------------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------------
    // Every line value is registered together with the state that owns it,
    // so data_out changes on the same edge as the state and never glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_word    <= '0;
            r_bit_cnt <= '0;
            r_period  <= '0;
            data_out  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    data_out  <= 1'b1;
                    busy      <= 1'b0;
                    r_bit_cnt <= '0;
                    r_period  <= '0;
                    // ready_out is high throughout IDLE, so valid_in alone
                    // completes the handshake here.
                    if (valid_in) begin
                        r_word   <= data_in;
                        r_state  <= S_START;
                        data_out <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                default: begin
                    if (r_period != c_LAST_TICK) begin
                        r_period <= r_period + c_PER_ONE;
                    end else begin
                        // Bit boundary: reload the period counter and put
                        // the next line bit out on this same edge.
                        r_period <= '0;

                        case (r_state)
                            S_START: begin
                                r_state   <= S_DATA;
                                r_bit_cnt <= '0;
                                data_out  <= w_next_bit;
                            end

                            S_DATA: begin
                                if (r_bit_cnt == c_LAST_DATA) begin
                                    r_bit_cnt <= '0;
`ifdef FRAME_SERIALIZER_PARITY_EN
                                    r_state   <= S_PARITY;
                                    data_out  <= w_parity;
`else
                                    r_state   <= S_STOP;
                                    data_out  <= 1'b1;
`endif
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                                    data_out  <= w_next_bit;
                                end
                            end

`ifdef FRAME_SERIALIZER_PARITY_EN
                            S_PARITY: begin
                                r_state   <= S_STOP;
                                r_bit_cnt <= '0;
                                data_out  <= 1'b1;
                            end
`endif

                            S_STOP: begin
                                data_out <= 1'b1;
                                if (r_bit_cnt == c_LAST_STOP) begin
                                    r_state   <= S_IDLE;
                                    r_bit_cnt <= '0;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                                end
                            end

                            default: begin
                                // Unused encodings fall back to a quiet idle
                                // line without signalling completion.
                                r_state   <= S_IDLE;
                                r_bit_cnt <= '0;
                                data_out  <= 1'b1;
                                busy      <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_serializer
//  Description : Self-checking bench for frame_serializer. Three instances
//                share one stimulus stream: A (LSB first, 1 clk/bit, 1 stop),
//                B (MSB first, 1 clk/bit, 2 stops), C (LSB first, 4 clk/bit,
//                1 stop). A frame-level model predicts every output on every
//                cycle; directed frames pin the model with literal waveforms.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_serializer;

    localparam int c_N = 3;

`ifdef FRAME_SERIALIZER_PARITY_EN
    localparam int c_PAR = 1;
    // Literal line waveforms, start bit first.
    localparam logic [10:0] c_SEQ_0F_LSB = 11'b01111000001;
    localparam logic [11:0] c_SEQ_0F_MSB = 12'b000001111011;
    localparam logic [10:0] c_SEQ_A5     = 11'b01010010101;
    localparam logic [10:0] c_SEQ_07     = 11'b01110000011;
    localparam logic [22:0] c_SEQ_B2B    = 23'b01000100001100100010001;
`else
    localparam int c_PAR = 0;
    localparam logic [9:0]  c_SEQ_0F_LSB = 10'b0111100001;
    localparam logic [10:0] c_SEQ_0F_MSB = 11'b00000111111;
    localparam logic [9:0]  c_SEQ_A5     = 10'b0101001011;
    localparam logic [9:0]  c_SEQ_07     = 10'b0111000001;
    localparam logic [20:0] c_SEQ_B2B    = 21'b010001000110010001001;
`endif

    localparam int c_FA  = 10 + c_PAR;   // line bits per frame, instance A / C
    localparam int c_FB  = 11 + c_PAR;   // line bits per frame, instance B
    localparam int c_REC = 56;           // cycles recorded per directed frame

    logic                 clock    = 1'b0;
    logic                 reset    = 1'b1;
    logic                 valid_in = 1'b0;
    logic [7:0]           data_in  = 8'h00;
    logic [c_N-1:0]       ready_out;
    logic [c_N-1:0]       data_out;
    logic [c_N-1:0]       busy;
    logic [c_N-1:0]       done;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    frame_serializer #(.DATA_WIDTH(8), .BIT_PERIOD(1), .MSB_FIRST(0), .STOP_BITS(1)) u_dut_a (
        .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out[0]), .data_out(data_out[0]), .busy(busy[0]), .done(done[0]));

    frame_serializer #(.DATA_WIDTH(8), .BIT_PERIOD(1), .MSB_FIRST(1), .STOP_BITS(2)) u_dut_b (
        .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out[1]), .data_out(data_out[1]), .busy(busy[1]), .done(done[1]));

    frame_serializer #(.DATA_WIDTH(8), .BIT_PERIOD(4), .MSB_FIRST(0), .STOP_BITS(1)) u_dut_c (
        .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out[2]), .data_out(data_out[2]), .busy(busy[2]), .done(done[2]));

    // ------------------------------------------------------------------------
    // Checking helper
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: a frame is a list of line symbols, each repeated
    // BIT_PERIOD times with busy high, followed by one idle cycle with done.
    // Entries are {data_out, busy, done}.
    // ------------------------------------------------------------------------
    logic [2:0] q[c_N][$];
    logic [2:0] exp_cur[c_N];

    function automatic int bp_of(input int k);
        return (k == 2) ? 4 : 1;
    endfunction

    function automatic int sb_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic bit msb_of(input int k);
        return (k == 1);
    endfunction

    task automatic push_frame(input int k, input logic [7:0] w);
        logic sym[$];
        sym.push_back(1'b0);
        for (int b = 0; b < 8; b++) begin
            sym.push_back(msb_of(k) ? w[7-b] : w[b]);
        end
`ifdef FRAME_SERIALIZER_PARITY_EN
        sym.push_back(^w);
`endif
        for (int s = 0; s < sb_of(k); s++) sym.push_back(1'b1);
        foreach (sym[i]) begin
            for (int p = 0; p < bp_of(k); p++) q[k].push_back({sym[i], 1'b1, 1'b0});
        end
        q[k].push_back(3'b101);
    endtask

    // Compare process: outputs and inputs are both stable at the falling edge.
    initial begin
        for (int k = 0; k < c_N; k++) exp_cur[k] = 3'b100;
        forever begin
            @(negedge clock);
            for (int k = 0; k < c_N; k++) begin
                if (reset) begin
                    q[k].delete();
                    exp_cur[k] = 3'b100;
                end
                check($sformatf("line[%0d]", k),  {31'd0, data_out[k]}, {31'd0, exp_cur[k][2]});
                check($sformatf("busy[%0d]", k),  {31'd0, busy[k]},     {31'd0, exp_cur[k][1]});
                check($sformatf("done[%0d]", k),  {31'd0, done[k]},     {31'd0, exp_cur[k][0]});
                check($sformatf("ready[%0d]", k), {31'd0, ready_out[k]},
                      {31'd0, (reset || q[k].size() == 0)});
                if (!reset) begin
                    if (q[k].size() == 0 && valid_in) push_frame(k, data_in);
                    exp_cur[k] = (q[k].size() != 0) ? q[k].pop_front() : 3'b100;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed-frame capture
    // ------------------------------------------------------------------------
    logic [0:63] tr[c_N];
    int          nbusy[c_N];
    int          ndone[c_N];
    int          done_at[c_N];

    // All stimulus changes happen 2 time units after a rising edge.
    task automatic wait_all_ready();
        int n = 0;
        while (ready_out !== 3'b111 && n < 200) begin
            @(posedge clock); #2;
            n++;
        end
        check("wait_ready", {29'd0, ready_out}, 32'd7);
    endtask

    task automatic send_frame(input logic [7:0] w);
        wait_all_ready();
        valid_in = 1'b1;
        data_in  = w;
        @(posedge clock); #2;
        valid_in = 1'b0;
        data_in  = 8'($urandom);
        for (int k = 0; k < c_N; k++) begin
            tr[k] = '1; nbusy[k] = 0; ndone[k] = 0; done_at[k] = -1;
        end
        for (int cyc = 0; cyc < c_REC; cyc++) begin
            @(negedge clock);
            for (int k = 0; k < c_N; k++) begin
                tr[k][cyc] = data_out[k];
                nbusy[k] += int'(busy[k]);
                ndone[k] += int'(done[k]);
                if (done[k]) done_at[k] = cyc;
            end
            if (cyc == 3) data_in = 8'($urandom);
        end
        @(posedge clock); #2;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [0:15] dec;
        int          held_ok;

        repeat (3) @(posedge clock);
        #1;
        check("rst_line",  {29'd0, data_out},  32'd7);
        check("rst_busy",  {29'd0, busy},      32'd0);
        check("rst_done",  {29'd0, done},      32'd0);
        check("rst_ready", {29'd0, ready_out}, 32'd7);
        #1;
        reset = 1'b0;

        // 0x0F straight out of reset: accepted on the first rising edge.
        send_frame(8'h0F);
        check("a_0f_seq",    32'(tr[0][0:c_FA-1]), 32'(c_SEQ_0F_LSB));
        check("a_0f_doneat", done_at[0], c_FA);
        check("a_0f_ndone",  ndone[0], 1);
        check("b_0f_seq",    32'(tr[1][0:c_FB-1]), 32'(c_SEQ_0F_MSB));
        check("b_0f_doneat", done_at[1], c_FB);

        // 0xA5: four clocks per bit on C, parity 0 when enabled.
        send_frame(8'hA5);
        check("a_a5_seq", 32'(tr[0][0:c_FA-1]), 32'(c_SEQ_A5));
        held_ok = 1;
        dec     = '1;
        for (int b = 0; b < c_FA; b++) begin
            dec[b] = tr[2][4*b];
            for (int j = 1; j < 4; j++) if (tr[2][4*b+j] !== tr[2][4*b]) held_ok = 0;
        end
        check("c_a5_hold",   held_ok, 1);
        check("c_a5_seq",    32'(dec[0:c_FA-1]), 32'(c_SEQ_A5));
        check("c_a5_busy",   nbusy[2], 4 * c_FA);
        check("c_a5_ndone",  ndone[2], 1);
        check("c_a5_doneat", done_at[2], 4 * c_FA);

        // 0x07: parity 1 when enabled, frame length in bits.
        send_frame(8'h07);
        check("a_07_seq",    32'(tr[0][0:c_FA-1]), 32'(c_SEQ_07));
        check("a_07_doneat", done_at[0], c_FA);

        // Back-to-back 0x11 / 0x22 with valid held high and data churn.
        wait_all_ready();
        valid_in = 1'b1;
        data_in  = 8'h11;
        @(posedge clock); #2;
        data_in  = 8'h5A;
        tr[0] = '1; ndone[0] = 0;
        for (int cyc = 0; cyc < 2 * c_FA + 2; cyc++) begin
            @(negedge clock);
            tr[0][cyc] = data_out[0];
            ndone[0] += int'(done[0]);
            @(posedge clock); #2;
            if (cyc == 1) data_in = 8'hC3;
            if (cyc == 2) data_in = 8'h22;
            if (cyc == c_FA) valid_in = 1'b0;
        end
        check("b2b_seq",   32'(tr[0][0:2*c_FA]), 32'(c_SEQ_B2B));
        check("b2b_ndone", ndone[0], 2);

        // Reset during the 4th payload bit of instance A.
        wait_all_ready();
        valid_in = 1'b1;
        data_in  = 8'h0F;
        @(posedge clock); #2;
        valid_in = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check("mid_busy_pre", {31'd0, busy[0]}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_line", {29'd0, data_out}, 32'd7);
        check("mid_busy", {29'd0, busy}, 32'd0);
        ndone[0] = 0;
        @(posedge clock); #2;
        reset = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clock);
            ndone[0] += int'(done[0]);
        end
        check("mid_ndone", ndone[0], 0);
        @(posedge clock); #2;
        send_frame(8'h0F);
        check("post_rst_seq", 32'(tr[0][0:c_FA-1]), 32'(c_SEQ_0F_LSB));
        check("post_rst_doneat", done_at[0], c_FA);

        // Randomised traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = 8'($urandom);
            reset    = ($urandom_range(0, 299) == 0);
            @(posedge clock); #2;
        end
        reset    = 1'b0;
        valid_in = 1'b0;
        repeat (60) @(posedge clock);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
